// File: rtl/dbg_dump_tx.sv
// dbg_dump_tx: debug register-dump transmitter.
// A rising edge on trig snapshots pc and bug, then walks the GPR read port
// from REG_FIRST to REG_LAST and sends the frame as 8N1 UART bytes:
//   HDR_BYTE, {7'b0,bug}, pc[4 bytes LE], regs[REG_FIRST..REG_LAST][4 bytes LE]
// Optional feature macro DBG_DUMP_CHKSUM_EN appends one byte. That byte is the
// XOR of every frame byte except the header.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset
//   trig     dump request (level, rising edge starts a dump)
//   bug      core bug flag, sampled at dump start
//   pc       instruction address, sampled at dump start
//   rd_addr  GPR read address
//   rd_data  GPR read data (combinational from rd_addr)
//   uart_tx  serial line, idle high
//   busy     high from dump start to end of the last stop bit
//   done     one-cycle pulse after the last stop bit
module dbg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 1085,
    parameter int unsigned REG_FIRST    = 1,
    parameter int unsigned REG_LAST     = 31,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic        bug,
    input  logic [31:0] pc,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NREG    = REG_LAST - REG_FIRST + 1;
    localparam int unsigned REG_END = 6 + 4 * NREG;  // index just past the last register byte
`ifdef DBG_DUMP_CHKSUM_EN
    localparam int unsigned NBYTES  = REG_END + 1;
`else
    localparam int unsigned NBYTES  = REG_END;
`endif
    localparam logic [7:0]  LAST_BYTE  = 8'(NBYTES - 1);
    localparam logic [15:0] BAUD_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  ADDR_FIRST = 5'(REG_FIRST);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  byte_q;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic [31:0] pc_q;
    logic        bug_q;
    logic [4:0]  rd_addr_q;
    logic        trig_q;
    logic        armed_q;
    logic        tx_q, busy_q, done_q;
`ifdef DBG_DUMP_CHKSUM_EN
    logic [7:0]  chk_q;
`endif

    // Byte lane within the current 32-bit word. pc starts at byte 2 and the
    // registers at byte 6, so both share lane = (byte_q - 2) mod 4.
    logic [1:0]  lane;
    logic        in_regs;
    logic [31:0] src_w;

    assign lane    = byte_q[1:0] + 2'd2;
    assign in_regs = (byte_q >= 8'd6);

    always_comb begin
        word_d  = word_q;
        if (in_regs && lane == 2'd0) begin
            word_d = rd_data;  // lane 0 snapshots the whole word, so later writes cannot tear it
        end
        src_w   = in_regs ? word_d : pc_q;
        case (lane)
            2'd0:    shift_d = src_w[7:0];
            2'd1:    shift_d = src_w[15:8];
            2'd2:    shift_d = src_w[23:16];
            default: shift_d = src_w[31:24];
        endcase
        if (byte_q == 8'd0) begin
            shift_d = HDR_BYTE;
        end else if (byte_q == 8'd1) begin
            shift_d = {7'b0, bug_q};
        end
`ifdef DBG_DUMP_CHKSUM_EN
        if (byte_q == 8'(REG_END)) begin
            shift_d = chk_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            pc_q      <= '0;
            bug_q     <= 1'b0;
            rd_addr_q <= ADDR_FIRST;
            trig_q    <= 1'b0;
            armed_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DBG_DUMP_CHKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            trig_q <= trig;
            // The edge history clears to 0 on reset, so a trig held high
            // through reset would look like an edge. Arm only after trig is seen low.
            if (!trig) begin
                armed_q <= 1'b1;
            end
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig && !trig_q && armed_q) begin
                        pc_q      <= pc;
                        bug_q     <= bug;
                        busy_q    <= 1'b1;
                        rd_addr_q <= ADDR_FIRST;
                        byte_q    <= '0;
`ifdef DBG_DUMP_CHKSUM_EN
                        chk_q     <= '0;
`endif
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q <= shift_d;
                    word_q  <= word_d;
`ifdef DBG_DUMP_CHKSUM_EN
                    if (byte_q != 8'd0) begin
                        chk_q <= chk_q ^ shift_d;
                    end
`endif
                    if (in_regs && lane == 2'd3) begin
                        rd_addr_q <= rd_addr_q + 5'd1;
                    end
                    baud_q  <= '0;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q <= '0;
                        if (byte_q == LAST_BYTE) begin
                            byte_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            byte_q  <= byte_q + 8'd1;
                            state_q <= LOAD;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_addr = rd_addr_q;
    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dbg_dump_tx.sv
// Testbench for dbg_dump_tx. Two instances: u0 with the default register
// range and u1 dumping only x1. UART lines are decoded into byte queues and
// compared with frames built directly from the frame layout rules.
module tb_dbg_dump_tx;

    localparam int CPB = 4;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tr0, tr1, bug0, bug1;
    logic [31:0] pc0, pc1, rd0, rd1;
    logic [4:0]  ra0, ra1;
    logic        tx0, tx1, busy0, busy1, done0, done1;
    logic [31:0] regs0 [32];
    logic [31:0] regs1 [32];
    logic [1:0]  txv;

    assign rd0 = regs0[ra0];
    assign rd1 = regs1[ra1];
    assign txv = {tx1, tx0};

    int  tests = 0;
    int  fails = 0;
    int  dn0 = 0;
    int  dn1 = 0;
    bq_t rxq0, rxq1;

    dbg_dump_tx #(.CLKS_PER_BIT(CPB), .REG_FIRST(1), .REG_LAST(31), .HDR_BYTE(8'hA5)) u0 (
        .clk(clk), .rst(rst), .trig(tr0), .bug(bug0), .pc(pc0), .rd_addr(ra0),
        .rd_data(rd0), .uart_tx(tx0), .busy(busy0), .done(done0));

    dbg_dump_tx #(.CLKS_PER_BIT(CPB), .REG_FIRST(1), .REG_LAST(1), .HDR_BYTE(8'hA5)) u1 (
        .clk(clk), .rst(rst), .trig(tr1), .bug(bug1), .pc(pc1), .rd_addr(ra1),
        .rd_data(rd1), .uart_tx(tx1), .busy(busy1), .done(done1));

    always @(negedge clk) begin
        if (done0 === 1'b1) dn0++;
        if (done1 === 1'b1) dn1++;
    end

    // 8N1 receiver: sample mid-bit on negedges after detecting the start bit.
    task automatic rx_loop(input int ch);
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txv[ch] === 1'b0) begin
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    if (i != 0) repeat (CPB) @(negedge clk);
                    b[i] = txv[ch];
                end
                repeat (CPB) @(negedge clk);
                if (ch == 0) rxq0.push_back(b);
                else         rxq1.push_back(b);
            end
            prev = txv[ch];
        end
    endtask

    initial rx_loop(0);
    initial rx_loop(1);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input logic [31:0] pcv, input logic bugv, input int first,
                             input int last, input logic [31:0] rv [32], output bq_t q);
        logic [7:0] x;
        q = {};
        q.push_back(8'hA5);
        q.push_back({7'b0, bugv});
        for (int k = 0; k < 4; k++) q.push_back(8'(pcv >> (8 * k)));
        for (int r = first; r <= last; r++)
            for (int k = 0; k < 4; k++) q.push_back(8'(rv[r] >> (8 * k)));
`ifdef DBG_DUMP_CHKSUM_EN
        x = 8'h00;
        for (int i = 1; i < q.size(); i++) x = x ^ q[i];
        q.push_back(x);
`endif
    endtask

    task automatic cmp_frame(input string tag, input bq_t got, input bq_t exp);
        int bad;
        bad = 0;
        check({tag, ".len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) bad++;
        check({tag, ".bad_bytes"}, 64'(bad), 64'd0);
    endtask

    task automatic wait_done(input int ch, input int budget, output bit ok, output int busy_low);
        ok = 1'b0;
        busy_low = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((ch == 0 ? done0 : done1) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if ((ch == 0 ? busy0 : busy1) !== 1'b1) busy_low++;
        end
    endtask

    initial begin
        bq_t        exp, exp3, lit, got3;
        logic       wave [64];
        logic [7:0] hdr;
        logic [31:0] pcs;
        bit         ok;
        int         bl, bl2, d0, d1, first_low, width, bad, ones, sec, n, bhi, tlo;

        rst = 1'b0; tr0 = 1'b0; tr1 = 1'b0; bug0 = 1'b0; bug1 = 1'b0; pc0 = '0; pc1 = '0;
        for (int i = 0; i < 32; i++) begin
            regs0[i] = '0;
            regs1[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.uart_tx", tx0, 1);
        check("reset.busy", busy0, 0);
        check("reset.done", done0, 0);
        check("reset.rd_addr", ra0, 1);
        check("reset.u1.uart_tx", tx1, 1);
        check("reset.u1.rd_addr", ra1, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Frame with x[r] = 0x01010101*r, pc=0x80, bug=0; bit timing of the header byte
        for (int r = 1; r < 32; r++) regs0[r] = 32'(r) * 32'h0101_0101;
        pc0 = 32'h0000_0080; bug0 = 1'b0;
        build_exp(pc0, bug0, 1, 31, regs0, exp);
        rxq0 = {}; d0 = dn0;
        tr0 = 1'b1;
        bl = 0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            wave[i] = tx0;
            if (busy0 !== 1'b1) bl++;
        end
        first_low = -1;
        for (int i = 0; i < 44; i++) if (wave[i] === 1'b0 && first_low < 0) first_low = i;
        check("t2.first_fall_cycles", 64'(first_low + 1), 2);
        width = 0;
        for (int i = 1; i < 10; i++) if (wave[i] === 1'b0 && i < 5) width++;
        check("t2.start_width", 64'(width), 4);
        check("t2.after_start", wave[5], 1);
        hdr = 8'hA5; bad = 0;
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < CPB; c++)
                if (wave[5 + 4 * b + c] !== hdr[b]) bad++;
        check("t2.hdr_bits", 64'(bad), 0);
        ones = 0;
        for (int i = 37; i <= 41; i++) if (wave[i] === 1'b1) ones++;
        check("t2.stop_and_gap", 64'(ones), 5);
        sec = -1;
        for (int i = 37; i < 44; i++) if (wave[i] === 1'b0 && sec < 0) sec = i;
        check("t2.byte_period", 64'(sec - first_low), 41);
        wait_done(0, 140 * 41, ok, bl2);
        check("t1.done_seen", ok, 1);
        @(negedge clk);
        check("t1.busy_low_cycles", 64'(bl + bl2), 0);
        check("t1.done_pulses", 64'(dn0 - d0), 1);
        check("t1.idle_busy", busy0, 0);
        check("t1.idle_tx", tx0, 1);
        cmp_frame("t1.frame", rxq0, exp);

        // Single-register instance, fixed vector
        regs1[1] = 32'h1122_3344; pc1 = '0; bug1 = 1'b1;
        lit = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef DBG_DUMP_CHKSUM_EN
        lit.push_back(8'h45);
`endif
        rxq1 = {}; d1 = dn1;
        tr1 = 1'b1;
        wait_done(1, 20 * 41, ok, bl);
        @(negedge clk);
        check("t6.done_seen", ok, 1);
        check("t6.done_pulses", 64'(dn1 - d1), 1);
        cmp_frame("t6.frame", rxq1, lit);
        tr1 = 1'b0;
        @(negedge clk);

        // Single-register instance, random vector
        regs1[1] = $urandom; pc1 = $urandom; bug1 = 1'($urandom_range(0, 1));
        build_exp(pc1, bug1, 1, 1, regs1, exp);
        rxq1 = {};
        tr1 = 1'b1;
        wait_done(1, 20 * 41, ok, bl);
        @(negedge clk);
        check("t6r.done_seen", ok, 1);
        cmp_frame("t6r.frame", rxq1, exp);

        // Random frame; x5 mutated after its capture, pc changed, trig toggled mid-frame
        tr0 = 1'b0;
        @(negedge clk);
        for (int r = 1; r < 32; r++) regs0[r] = $urandom;
        regs0[5] = 32'h0505_0505;
        pc0 = $urandom; bug0 = 1'($urandom_range(0, 1)); pcs = pc0;
        build_exp(pc0, bug0, 1, 31, regs0, exp3);
        rxq0 = {}; d0 = dn0;
        tr0 = 1'b1;
        repeat (100) @(posedge clk);
        #1 pc0 = $urandom; tr0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 tr0 = 1'b1;
        repeat (5) @(posedge clk);
        #1 tr0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 tr0 = 1'b1;
        repeat (904 - 115) @(posedge clk);
        #1 regs0[5] = 32'hDEAD_BEEF;
        repeat (200) @(posedge clk);
        #1 regs0[5] = 32'h0505_0505; pc0 = pcs; tr0 = 1'b0;
        wait_done(0, 140 * 41, ok, bl);
        tr0 = 1'b1;  // edge lands in the done cycle
        got3 = rxq0;
        rxq0 = {};
        @(negedge clk);
        check("t3.done_seen", ok, 1);
        check("t4.restart_in_done_cycle", busy0, 1);
        check("t4.done_pulses", 64'(dn0 - d0), 1);
        check("t3.busy_low_cycles", 64'(bl), 0);
        cmp_frame("t3.frame", got3, exp3);

        // Reset during byte 40 of the repeated frame, trig held high
        repeat (1645) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5.reset_tx", tx0, 1);
        check("t5.reset_busy", busy0, 0);
        rst = 1'b1;
        d0 = dn0;
        repeat (100) @(negedge clk);
        n = rxq0.size();
        check("t5.partial_has_40", 64'(n >= 40), 1);
        bad = 0;
        for (int i = 0; i < 40; i++) if (i >= n || rxq0[i] !== exp3[i]) bad++;
        check("t4.second_frame_prefix", 64'(bad), 0);
        bhi = 0; tlo = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy0 !== 1'b0) bhi++;
            if (tx0 !== 1'b1) tlo++;
        end
        check("t5.no_restart_busy", 64'(bhi), 0);
        check("t5.no_restart_tx", 64'(tlo), 0);
        check("t5.no_done", 64'(dn0 - d0), 0);
        check("t5.no_new_bytes", 64'(rxq0.size()), 64'(n));

        // Fresh edge after reset starts a new random frame
        tr0 = 1'b0;
        repeat (2) @(negedge clk);
        for (int r = 1; r < 32; r++) regs0[r] = $urandom;
        pc0 = $urandom; bug0 = 1'($urandom_range(0, 1));
        build_exp(pc0, bug0, 1, 31, regs0, exp);
        rxq0 = {}; d0 = dn0;
        tr0 = 1'b1;
        wait_done(0, 140 * 41, ok, bl);
        @(negedge clk);
        check("t7.done_seen", ok, 1);
        check("t7.busy_low_cycles", 64'(bl), 0);
        check("t7.done_pulses", 64'(dn0 - d0), 1);
        cmp_frame("t7.frame", rxq0, exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
